// File: rtl/bus_xfer_ctrl.sv
// Shared-bus transfer controller: sequences MOVE/LOAD/CLEAR between register slots
// through read, write and clear strobes, with every output registered.
module bus_xfer_ctrl #(
  parameter int unsigned N    = 8,
  parameter int unsigned NREG = 4
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    req,
  input  logic [1:0]              op,
  input  logic [$clog2(NREG)-1:0] src,
  input  logic [$clog2(NREG)-1:0] dst,
  input  logic [N-1:0]            din,
  input  logic [N-1:0]            bus_in,
  output logic [N-1:0]            bus_out,
  output logic                    bus_oe,
  output logic [NREG-1:0]         RD_n,
  output logic [NREG-1:0]         WR_n,
  output logic [NREG-1:0]         Clr_n,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int unsigned IW = $clog2(NREG);

  localparam logic [1:0] OP_MOVE  = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;

  typedef enum logic [2:0] {IDLE, RD1, RD2, WR, CLR, DONE} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   src_q, src_nxt;
  logic [IW-1:0]   dst_q, dst_nxt;
  logic [N-1:0]    hold, hold_nxt;
  logic [N-1:0]    bus_out_nxt;
  logic            bus_oe_nxt, busy_nxt, done_nxt, err_nxt;
  logic [NREG-1:0] rd_nxt, wr_nxt, clr_nxt;
  logic            bad_c;

  // Illegal opcode or any index outside the populated slots is rejected up front.
  always_comb begin
    bad_c = (op == 2'b11) || (32'(dst) >= NREG) ||
            ((op == OP_MOVE) && (32'(src) >= NREG));
  end

  // Next state, latched operands, and Moore outputs decoded from the next state.
  always_comb begin
    state_nxt = state;
    src_nxt   = src_q;
    dst_nxt   = dst_q;
    hold_nxt  = hold;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (bad_c) begin
            err_nxt = 1'b1;
          end else begin
            src_nxt = src;
            dst_nxt = dst;
            case (op)
              OP_MOVE:  state_nxt = RD1;
              OP_LOAD:  begin state_nxt = WR; hold_nxt = din; end
              OP_CLEAR: state_nxt = CLR;
              default:  state_nxt = IDLE;
            endcase
          end
        end
      end
      RD1:     state_nxt = RD2;
      RD2:     begin state_nxt = WR; hold_nxt = bus_in; end
      WR:      state_nxt = DONE;
      CLR:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    rd_nxt      = '1;
    wr_nxt      = '1;
    clr_nxt     = '1;
    bus_oe_nxt  = 1'b0;
    bus_out_nxt = '0;
    if ((state_nxt == RD1) || (state_nxt == RD2)) rd_nxt = ~(NREG'(1) << src_nxt);
    if (state_nxt == WR) begin
      wr_nxt      = ~(NREG'(1) << dst_nxt);
      bus_oe_nxt  = 1'b1;
      bus_out_nxt = hold_nxt;
    end
    if (state_nxt == CLR) clr_nxt = ~(NREG'(1) << dst_nxt);
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_nxt == DONE);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state   <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      hold    <= '0;
      RD_n    <= '1;
      WR_n    <= '1;
      Clr_n   <= '1;
      bus_oe  <= 1'b0;
      bus_out <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      src_q   <= src_nxt;
      dst_q   <= dst_nxt;
      hold    <= hold_nxt;
      RD_n    <= rd_nxt;
      WR_n    <= wr_nxt;
      Clr_n   <= clr_nxt;
      bus_oe  <= bus_oe_nxt;
      bus_out <= bus_out_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      err     <= err_nxt;
    end
  end

endmodule

// File: doc/bus_xfer_ctrl.md
BUS_XFER_CTRL -- requirements
Module: bus_xfer_ctrl

Interface
REQ-001 Parameter: N, 8, data/bus width in bits.
REQ-002 Parameter: NREG, 4, number of register slots on the shared bus (2..16).
REQ-003 Port: Clk  input  1  sole clock; all controller state updates on posedge Clk.
REQ-004 Port: Rst  input  1  synchronous, active-high reset.
REQ-005 Port: req  input  1  operation request, sampled only in IDLE.
REQ-006 Port: op  input  2  operation: 00 MOVE, 01 LOAD, 10 CLEAR, 11 illegal.
REQ-007 Port: src  input  $clog2(NREG)  source slot index (MOVE only).
REQ-008 Port: dst  input  $clog2(NREG)  destination slot index.
REQ-009 Port: din  input  N  external data for LOAD.
REQ-010 Port: bus_in  input  N  resolved shared bus value (register tristate outputs).
REQ-011 Port: bus_out  output  N  data the controller drives onto the bus.
REQ-012 Port: bus_oe  output  1  bus_out drive enable; external tristate gated by it.
REQ-013 Port: RD_n  output  NREG  per-slot active-low read strobes.
REQ-014 Port: WR_n  output  NREG  per-slot active-low write strobes.
REQ-015 Port: Clr_n  output  NREG  per-slot active-low clear strobes.
REQ-016 Port: busy  output  1  high in every state except IDLE.
REQ-017 Port: done  output  1  one-cycle pulse on completion of a legal operation.
REQ-018 Port: err  output  1  one-cycle pulse on rejection of an illegal request.

Function
REQ-019 States SHALL be IDLE, RD1, RD2, WR, CLR, DONE; all outputs registered (Moore).
REQ-020 In IDLE with req=1, op, src, dst, din SHALL be latched; later input changes have no effect until the next IDLE.
REQ-021 Transitions from IDLE on req: MOVE->RD1, LOAD->WR (hold<=din), CLEAR->CLR, op=11->IDLE with err=1 for one cycle.
REQ-022 RD1->RD2->WR; RD_n[src]=0 throughout RD1 and RD2; hold<=bus_in at the posedge leaving RD2.
REQ-023 WR: WR_n[dst]=0, bus_oe=1, bus_out=hold for exactly one cycle; then DONE.
REQ-024 CLR: Clr_n[dst]=0 for exactly one cycle; then DONE.
REQ-025 DONE: done=1 for one cycle; next state IDLE; req is not sampled in DONE.
REQ-026 Latency from the req-accept edge to done high: MOVE 4 cycles, LOAD 2, CLEAR 2; back-to-back requests start no sooner than the cycle after DONE.
REQ-027 At most one bit across RD_n, WR_n and Clr_n combined SHALL be low in any cycle.
REQ-028 bus_oe SHALL never be 1 while any RD_n bit is 0 (no bus contention).
REQ-029 bus_out SHALL be 0 whenever bus_oe=0.
REQ-030 Strobes SHALL be stable for a full Clk period so that a slot register sampling on negedge sees exactly one active edge per strobe.
REQ-031 MOVE with src==dst SHALL execute the normal sequence and complete with done.
REQ-032 Out-of-range index (>=NREG) SHALL be rejected in IDLE like op=11: err pulse, no strobe.
REQ-033 req while busy SHALL be ignored and not queued.

Reset
REQ-034 Rst=1 at a posedge SHALL force IDLE, with RD_n, WR_n, Clr_n all ones, bus_oe=0, bus_out=0, hold=0, busy=0, done=0, err=0 from the next cycle.
REQ-035 Rst SHALL take priority over req and over any in-progress operation; an aborted operation produces no done and no further strobes.

Verification
REQ-036 Reset, then MOVE src=1 dst=2 with slot1 holding 8'hA5 -> RD_n=4'b1101 for 2 cycles, then WR_n=4'b1011 with bus_out=8'hA5 and bus_oe=1, done at cycle 4, slot2=8'hA5.
REQ-037 LOAD dst=3 din=8'h3C -> next cycle WR_n=4'b0111, bus_out=8'h3C; done at cycle 2; busy high for cycles 1-2.
REQ-038 CLEAR dst=0 -> Clr_n=4'b1110 for one cycle, done at cycle 2, slot0=0.
REQ-039 op=11 -> err=1 for one cycle, busy stays 0, all strobes stay high; a second req during MOVE is ignored.
REQ-040 Rst asserted during RD2 of a MOVE -> next cycle IDLE, all strobes high, bus_oe=0, no done, destination unchanged.
REQ-041 Every cycle of every test asserts REQ-027, REQ-028 and REQ-029.
